// File: rtl/miner_job_ctrl.sv
// Job/report controller between a byte-wide host link and a hash core:
// assembles 52-byte job frames, pulses the miner on commit, reports golden nonces.
module miner_job_ctrl #(
  parameter logic [23:0] RX_TIMEOUT = 24'd10_000_000,
  parameter logic [7:0]  REPORT_HDR = 8'hA5
) (
  input  logic         hash_clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] midstate,
  output logic [95:0]  work_data,
  output logic [31:0]  nonce_min,
  output logic [31:0]  nonce_max,
  output logic         miner_reset,
  input  logic [31:0]  golden_nonce,
  input  logic         new_golden_nonce,
  output logic         mining
);

  typedef enum logic [1:0] {IDLE, START, MINING, REPORT} state_t;

  state_t         state_q, state_d;
  logic [5:0]     byte_cnt_q;
  logic [23:0]    to_cnt_q;
  logic [2:0]     tx_idx_q;
  logic [415:0]   shadow_q;
  logic [31:0]    nonce_lat_q;
  logic           ngn_prev_q;
  logic           rx_ready_q, tx_valid_q, miner_reset_q, mining_q;
  logic [7:0]     tx_data_q;
  logic [255:0]   midstate_q;
  logic [95:0]    work_data_q;
  logic [31:0]    nonce_min_q, nonce_max_q;

  logic           rx_fire, frame_done, gn_rise, tx_fire;
  logic [7:0]     tx_next_byte;

  always_comb begin
    rx_fire    = rx_valid && rx_ready_q;
    frame_done = rx_fire && (byte_cnt_q == 6'd51);
    gn_rise    = new_golden_nonce && !ngn_prev_q;
    tx_fire    = tx_valid_q && tx_ready;
    state_d    = state_q;
    case (state_q)
      IDLE:    if (frame_done) state_d = START;
      START:   state_d = MINING;
      MINING:  if (frame_done) state_d = START;
               else if (gn_rise) state_d = REPORT;
      REPORT:  if (tx_fire && (tx_idx_q == 3'd4)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (tx_idx_q)
      3'd0:    tx_next_byte = nonce_lat_q[31:24];
      3'd1:    tx_next_byte = nonce_lat_q[23:16];
      3'd2:    tx_next_byte = nonce_lat_q[15:8];
      default: tx_next_byte = nonce_lat_q[7:0];
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      tx_idx_q      <= '0;
      shadow_q      <= '0;
      nonce_lat_q   <= '0;
      ngn_prev_q    <= 1'b0;
      rx_ready_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      miner_reset_q <= 1'b0;
      mining_q      <= 1'b0;
      midstate_q    <= '0;
      work_data_q   <= '0;
      nonce_min_q   <= '0;
      nonce_max_q   <= '0;
    end else begin
      state_q       <= state_d;
      ngn_prev_q    <= new_golden_nonce;
      rx_ready_q    <= (state_d == IDLE) || (state_d == MINING);
      miner_reset_q <= (state_d == START);
      mining_q      <= (state_d == MINING);

      // Bytes arrive MSB-first, so shifting in is equivalent to writing
      // the slot addressed by byte_cnt_q; the counter still tracks fill level.
      if (rx_fire) begin
        to_cnt_q <= '0;
        if (frame_done) begin
          {midstate_q, work_data_q, nonce_min_q, nonce_max_q} <= {shadow_q[407:0], rx_data};
          byte_cnt_q <= '0;
        end else begin
          shadow_q   <= {shadow_q[407:0], rx_data};
          byte_cnt_q <= byte_cnt_q + 6'd1;
        end
      end else if (byte_cnt_q != '0) begin
        if (to_cnt_q == RX_TIMEOUT) begin
          byte_cnt_q <= '0;
          to_cnt_q   <= '0;
          shadow_q   <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 24'd1;
        end
      end

      if ((state_q == MINING) && (state_d == REPORT)) begin
        nonce_lat_q <= golden_nonce;
        tx_valid_q  <= 1'b1;
        tx_data_q   <= REPORT_HDR;
        tx_idx_q    <= '0;
      end else if (tx_fire) begin
        if (tx_idx_q == 3'd4) begin
          tx_valid_q <= 1'b0;
          tx_idx_q   <= '0;
        end else begin
          tx_data_q <= tx_next_byte;
          tx_idx_q  <= tx_idx_q + 3'd1;
        end
      end
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign miner_reset = miner_reset_q;
  assign mining      = mining_q;
  assign midstate    = midstate_q;
  assign work_data   = work_data_q;
  assign nonce_min   = nonce_min_q;
  assign nonce_max   = nonce_max_q;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Directed/randomized bench for miner_job_ctrl with a frame-level reference model.
module tb_miner_job_ctrl;
  localparam logic [23:0] TO  = 24'd40;
  localparam logic [7:0]  HDR = 8'hA5;

  logic         hash_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [255:0] midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_min, nonce_max;
  logic         miner_reset;
  logic [31:0]  golden_nonce = '0;
  logic         new_golden_nonce = 1'b0;
  logic         mining;

  int n_tests = 0;
  int n_fail  = 0;
  int mr_cnt  = 0;
  logic [7:0] frame [52];
  logic [7:0] tx_q [$];

  miner_job_ctrl #(.RX_TIMEOUT(TO), .REPORT_HDR(HDR)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .midstate(midstate), .work_data(work_data),
    .nonce_min(nonce_min), .nonce_max(nonce_max),
    .miner_reset(miner_reset), .golden_nonce(golden_nonce),
    .new_golden_nonce(new_golden_nonce), .mining(mining)
  );

  always #5 hash_clk = ~hash_clk;

  always @(posedge hash_clk) begin
    if (reset_n && tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (miner_reset) mr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_job(input string tag);
    logic [255:0] em;
    logic [95:0]  ew;
    logic [31:0]  e0, e1;
    for (int i = 0; i < 32; i++) em[255-8*i -: 8] = frame[i];
    for (int i = 0; i < 12; i++) ew[95-8*i -: 8]  = frame[32+i];
    for (int i = 0; i < 4; i++) begin
      e0[31-8*i -: 8] = frame[44+i];
      e1[31-8*i -: 8] = frame[48+i];
    end
    chk({tag, ".midstate"}, midstate, em);
    chk({tag, ".work_data"}, 256'(work_data), 256'(ew));
    chk({tag, ".nonce_min"}, 256'(nonce_min), 256'(e0));
    chk({tag, ".nonce_max"}, 256'(nonce_max), 256'(e1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rx_ready"}, 256'(rx_ready), 256'(0));
    chk({tag, ".tx_valid"}, 256'(tx_valid), 256'(0));
    chk({tag, ".tx_data"}, 256'(tx_data), 256'(0));
    chk({tag, ".miner_reset"}, 256'(miner_reset), 256'(0));
    chk({tag, ".mining"}, 256'(mining), 256'(0));
    chk({tag, ".midstate"}, midstate, 256'(0));
    chk({tag, ".work_data"}, 256'(work_data), 256'(0));
    chk({tag, ".nonce_min"}, 256'(nonce_min), 256'(0));
    chk({tag, ".nonce_max"}, 256'(nonce_max), 256'(0));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 200) begin
      @(negedge hash_clk);
      n++;
    end
    if (!rx_ready) chk("rx_handshake", 256'(rx_ready), 256'(1));
    @(negedge hash_clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge hash_clk);
      send_byte(frame[i]);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 52; i++) frame[i] = 8'($urandom);
  endtask

  task automatic collect(input string tag, input logic [31:0] n, input bit toggle);
    logic [7:0] exp_b [5];
    int unsigned cyc = 0;
    exp_b[0] = HDR;
    for (int k = 1; k < 5; k++) exp_b[k] = 8'((n >> (32 - 8*k)) & 32'hFF);
    while (tx_q.size() < 5 && cyc < 200) begin
      tx_ready = toggle ? ~tx_ready : 1'b1;
      @(negedge hash_clk);
      cyc++;
    end
    tx_ready = 1'b1;
    repeat (10) @(negedge hash_clk);
    chk({tag, ".count"}, 256'(tx_q.size()), 256'(5));
    for (int k = 0; k < 5 && k < tx_q.size(); k++) chk({tag, ".byte"}, 256'(tx_q[k]), 256'(exp_b[k]));
    chk({tag, ".idle_mining"}, 256'(mining), 256'(0));
    chk({tag, ".idle_rx_ready"}, 256'(rx_ready), 256'(1));
    chk({tag, ".idle_tx_valid"}, 256'(tx_valid), 256'(0));
    tx_ready = 1'b0;
  endtask

  initial begin
    int m0;
    logic [31:0] nv;

    // Reset state and first ready
    repeat (3) @(negedge hash_clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge hash_clk);
    chk("post_reset.rx_ready", 256'(rx_ready), 256'(1));

    // Directed job load with rx_valid held high
    for (int i = 0; i < 32; i++) frame[i] = 8'(i + 1);
    for (int i = 0; i < 12; i++) frame[32+i] = 8'(8'hA1 + i);
    for (int i = 44; i < 48; i++) frame[i] = 8'h00;
    for (int i = 48; i < 52; i++) frame[i] = 8'hFF;
    m0 = mr_cnt;
    send_frame(0, 0, 29);
    chk("partial.midstate_untouched", midstate, 256'(0));
    send_frame(0, 30, 51);
    chk("load.miner_reset", 256'(miner_reset), 256'(1));
    chk("load.start_rx_ready", 256'(rx_ready), 256'(0));
    chk("load.start_mining", 256'(mining), 256'(0));
    check_job("load");
    @(negedge hash_clk);
    chk("load.mining", 256'(mining), 256'(1));
    chk("load.mr_low", 256'(miner_reset), 256'(0));
    repeat (3) @(negedge hash_clk);
    chk("load.mr_pulses", 256'(mr_cnt - m0), 256'(1));

    // Directed report, level held high, tx_ready toggling
    tx_q.delete();
    golden_nonce = 32'h0E33337A;
    new_golden_nonce = 1'b1;
    @(negedge hash_clk);
    chk("rpt.tx_valid", 256'(tx_valid), 256'(1));
    chk("rpt.tx_hdr", 256'(tx_data), 256'(HDR));
    chk("rpt.rx_ready", 256'(rx_ready), 256'(0));
    collect("rpt", 32'h0E33337A, 1);
    new_golden_nonce = 1'b0;
    @(negedge hash_clk);

    // Rising edge in IDLE is ignored
    tx_q.delete();
    new_golden_nonce = 1'b1;
    repeat (4) @(negedge hash_clk);
    chk("idle_edge.tx_valid", 256'(tx_valid), 256'(0));
    chk("idle_edge.no_bytes", 256'(tx_q.size()), 256'(0));
    new_golden_nonce = 1'b0;

    // Backpressure during REPORT
    rand_frame();
    send_frame(1, 0, 51);
    repeat (2) @(negedge hash_clk);
    check_job("bp_load");
    tx_q.delete();
    nv = $urandom;
    golden_nonce = nv;
    new_golden_nonce = 1'b1;
    @(negedge hash_clk);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (20) begin
      chk("bp.tx_valid", 256'(tx_valid), 256'(1));
      chk("bp.tx_data", 256'(tx_data), 256'(HDR));
      chk("bp.rx_ready", 256'(rx_ready), 256'(0));
      @(negedge hash_clk);
    end
    rx_valid = 1'b0;
    collect("bp_rpt", nv, 0);
    new_golden_nonce = 1'b0;

    // Stall shorter than the timeout keeps the partial frame
    rand_frame();
    send_frame(0, 0, 9);
    repeat (int'(TO) - 5) @(negedge hash_clk);
    send_frame(0, 10, 51);
    @(negedge hash_clk);
    check_job("short_stall");

    // Stall past the timeout discards it; committed job unchanged
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    repeat (int'(TO) + 5) @(negedge hash_clk);
    check_job("timeout_keep");
    rand_frame();
    send_frame(0, 0, 51);
    @(negedge hash_clk);
    check_job("timeout_new");

    // Preemption while mining
    repeat (2) @(negedge hash_clk);
    m0 = mr_cnt;
    rand_frame();
    send_frame(1, 0, 51);
    chk("preempt.miner_reset", 256'(miner_reset), 256'(1));
    repeat (3) @(negedge hash_clk);
    chk("preempt.mr_pulses", 256'(mr_cnt - m0), 256'(1));
    chk("preempt.mining", 256'(mining), 256'(1));
    check_job("preempt");

    // Frame commit and golden-nonce rise on the same edge
    tx_q.delete();
    rand_frame();
    send_frame(0, 0, 50);
    golden_nonce = $urandom;
    new_golden_nonce = 1'b1;
    send_byte(frame[51]);
    chk("collide.miner_reset", 256'(miner_reset), 256'(1));
    chk("collide.tx_valid", 256'(tx_valid), 256'(0));
    tx_ready = 1'b1;
    repeat (20) @(negedge hash_clk);
    chk("collide.no_bytes", 256'(tx_q.size()), 256'(0));
    chk("collide.mining", 256'(mining), 256'(1));
    check_job("collide");

    // Reset mid-report
    tx_ready = 1'b0;
    new_golden_nonce = 1'b0;
    @(negedge hash_clk);
    new_golden_nonce = 1'b1;
    @(negedge hash_clk);
    chk("rst_rpt.started", 256'(tx_valid), 256'(1));
    reset_n = 1'b0;
    new_golden_nonce = 1'b0;
    @(negedge hash_clk);
    check_zero("rst_rpt");
    reset_n = 1'b1;
    tx_q.delete();
    tx_ready = 1'b1;
    repeat (10) @(negedge hash_clk);
    chk("rst_rpt.no_bytes", 256'(tx_q.size()), 256'(0));
    tx_ready = 1'b0;

    // Reset mid-frame, then clean reload
    rand_frame();
    send_frame(0, 0, 30);
    reset_n = 1'b0;
    @(negedge hash_clk);
    check_zero("rst_frame");
    reset_n = 1'b1;
    @(negedge hash_clk);
    rand_frame();
    send_frame(1, 0, 51);
    @(negedge hash_clk);
    check_job("reload");
    chk("reload.mining", 256'(mining), 256'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/miner_job_ctrl.md
MINER_JOB_CTRL -- requirements
Module: miner_job_ctrl

Interface
REQ-001 Parameter RX_TIMEOUT, default 24'd10_000_000, is the number of idle hash_clk cycles after which a partial job frame is discarded.
REQ-002 Parameter REPORT_HDR, default 8'hA5, is the header byte that precedes every golden-nonce report.
REQ-003 Port hash_clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port reset_n, input, 1: synchronous, active-low reset.
REQ-005 Port rx_data, input, 8: job byte from the host link.
REQ-006 Port rx_valid, input, 1: rx_data is valid.
REQ-007 Port rx_ready, output, 1: the block accepts a byte; a transfer occurs on an edge where rx_valid and rx_ready are both 1.
REQ-008 Port tx_data, output, 8: report byte to the host link.
REQ-009 Port tx_valid, output, 1: tx_data is valid.
REQ-010 Port tx_ready, input, 1: the host accepts tx_data; a transfer occurs on an edge where tx_valid and tx_ready are both 1.
REQ-011 Ports midstate (256), work_data (96), nonce_min (32) and nonce_max (32), outputs: the committed job presented to the miner.
REQ-012 Port miner_reset, output, 1: active-high one-cycle start pulse to the miner.
REQ-013 Port golden_nonce, input, 32: result nonce from the miner.
REQ-014 Port new_golden_nonce, input, 1: the miner's found flag, which is level-held once set.
REQ-015 Port mining, output, 1: high while in state MINING.

Function
REQ-016 The states are IDLE, START, MINING and REPORT.
REQ-017 rx_ready is registered and is 1 only in IDLE and MINING; it is 0 in START and REPORT.
REQ-018 Job frame format: 52 bytes, with fields in this order, each field MSB byte first:
- midstate (byte 0 -> midstate[255:248])
- work_data
- nonce_min
- nonce_max
REQ-019 Accepted bytes fill a shadow register indexed by a 6-bit byte counter (0..51); committed outputs are not altered until the frame is complete.
REQ-020 On the edge that accepts byte 51:
- the shadow register is copied atomically to midstate, work_data, nonce_min and nonce_max;
- the byte counter is cleared;
- the state becomes START.
REQ-021 START lasts exactly one cycle, with miner_reset=1; the next state is MINING; miner_reset is 0 in every other state.
REQ-022 A frame completing while in MINING preempts the current job: the new job is committed and the block goes through START, re-pulsing miner_reset.
REQ-023 An inter-byte timeout counter is cleared on every accepted byte and increments while the byte counter is nonzero with no byte accepted.
REQ-024 When the timeout counter reaches RX_TIMEOUT, the byte counter is cleared and the shadow contents are discarded; committed outputs are unchanged.
REQ-025 Golden-nonce detection is by rising edge of new_golden_nonce, using a registered previous value; a level held high causes no repeat report.
REQ-026 A rising edge detected in MINING latches golden_nonce and moves the state to REPORT; on the next cycle tx_valid=1 and tx_data=REPORT_HDR.
REQ-027 A rising edge detected in IDLE, START or REPORT is ignored.
REQ-028 REPORT sends 5 bytes: REPORT_HDR, then the latched nonce [31:24], [23:16], [15:8], [7:0].
REQ-029 tx_data and tx_valid are held stable until a transfer occurs; they advance by one byte per transfer.
REQ-030 After the transfer of the 5th byte, tx_valid=0 and the state becomes IDLE; a partial rx frame resumes from its current byte counter.
REQ-031 When a frame completes and a rising edge of new_golden_nonce occur on the same edge in MINING, the frame commit wins (state START); that nonce report is dropped.
REQ-032 A 3-bit tx byte index counts 0..4 and must not exceed 4.

Reset
REQ-033 While reset_n=0 at a clock edge, the block enters IDLE and takes these values:
- byte counter, timeout counter and tx index = 0;
- rx_ready = 0, tx_valid = 0, tx_data = 0, miner_reset = 0, mining = 0;
- midstate, work_data, nonce_min and nonce_max = 0;
- new_golden_nonce edge register = 0.
REQ-034 rx_ready becomes 1 on the first edge with reset_n=1.
REQ-035 Reset asserted mid-frame or mid-report aborts the frame or report with no further output.

Verification
REQ-036 Job load: stream 52 bytes with midstate=256'h01..20, work_data=96'hA1..AC, nonce_min=0, nonce_max=32'hFFFFFFFF, rx_valid held high. Required response: outputs match exactly, miner_reset=1 for exactly one cycle after byte 51, then mining=1.
REQ-037 Report: in MINING, raise new_golden_nonce (held high) with golden_nonce=32'h0E33337A, with tx_ready toggling 1/0. Required response: exactly 5 bytes A5,0E,33,33,7A, no repeat, then IDLE.
REQ-038 Backpressure and stability: hold tx_ready=0 for 20 cycles during REPORT. Required response: tx_data=A5 and tx_valid=1 stay stable, and rx_ready=0 throughout.
REQ-039 Timeout: send 10 bytes, then stall RX_TIMEOUT cycles, then send a full 52-byte frame. Required response: outputs reflect only the second frame.
REQ-040 Preemption and collision: complete a second frame while mining. Required response: miner_reset re-pulses and the new job is committed. In addition, complete a frame on the same edge as a new_golden_nonce rising edge; required response: START is entered and no tx bytes are sent.
REQ-041 Reset mid-frame: assert reset_n=0 after byte 30. Required response: all outputs zero; the next 52 bytes load cleanly.
